// File: rtl/gpu_command_queue.sv
// gpu_command_queue
//   Front end of the GPU draw pipeline. The host fills shadow registers through
//   a simple write port. A write to DRAW snapshots every shadow, colour-table
//   config included, into a show-ahead FIFO. The FIFO head is presented to the
//   rectangle stage through a valid/ready handshake.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid/ready   host write handshake
//   cmd_addr/data     register index (0-7) and write data
//   re_valid/ready    job handshake to the rectangle stage
//   re_*              head job fields: start, size, scale, mirror, colour table
//   pipe_idle         all downstream stages empty
//   busy              queue non-empty or downstream still working
//   fifo_level        number of queued jobs (0..DEPTH)
//   drop_count        DRAWs discarded for zero size (saturates at 255)
//
// Register map (write-only)
//   0 start_x[15:0]  start_y[31:16]
//   1 width[15:0]    height[31:16]
//   2 scale_x[15:0]  scale_y[31:16]   (0 is stored as 1)
//   3 mirror_x[0] mirror_y[1] use_ct[2] ct_type[7:3] ct_base[31:16]
//   4 DRAW
//   5-7 accepted, ignored

module gpu_command_queue #(
  parameter int DEPTH = 4,
  parameter int LVLW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_addr,
  input  logic [31:0]     cmd_data,
  output logic            re_valid,
  input  logic            re_ready,
  output logic [15:0]     re_start_x,
  output logic [15:0]     re_start_y,
  output logic [15:0]     re_width,
  output logic [15:0]     re_height,
  output logic [15:0]     re_scale_x,
  output logic [15:0]     re_scale_y,
  output logic            re_mirror_x,
  output logic            re_mirror_y,
  output logic            re_use_ct,
  output logic [4:0]      re_ct_type,
  output logic [15:0]     re_ct_base,
  input  logic            pipe_idle,
  output logic            busy,
  output logic [LVLW-1:0] fifo_level,
  output logic [7:0]      drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(DEPTH);
  localparam logic [4:0] CT_DEFAULT = 5'd16;

  localparam logic [2:0] A_START = 3'd0;
  localparam logic [2:0] A_SIZE  = 3'd1;
  localparam logic [2:0] A_SCALE = 3'd2;
  localparam logic [2:0] A_CFG   = 3'd3;
  localparam logic [2:0] A_DRAW  = 3'd4;

  typedef struct packed {
    logic [15:0] start_x;
    logic [15:0] start_y;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] scale_x;
    logic [15:0] scale_y;
    logic        mirror_x;
    logic        mirror_y;
    logic        use_ct;
    logic [4:0]  ct_type;
    logic [15:0] ct_base;
  } job_t;

  // A zero scale would make the rectangle stage divide by zero; treat it as unity.
  function automatic logic [15:0] fix_scale(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  // Only legal bit depths survive, and a job without a colour table always
  // carries 16 bpp so downstream never sees a stale palette depth.
  function automatic logic [4:0] fix_ct(input logic use_ct, input logic [4:0] t);
    logic legal;
    legal = (t == 5'd1) || (t == 5'd2) || (t == 5'd4) || (t == 5'd8) || (t == 5'd16);
    return (use_ct && legal) ? t : CT_DEFAULT;
  endfunction

  job_t            shadow;
  job_t            mem [DEPTH];
  job_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LVLW-1:0] level;

  logic wr_acc;
  logic draw;
  logic push;
  logic pop;

  assign cmd_ready = !rst && (level != FULL_LVL);
  assign wr_acc    = cmd_valid && cmd_ready;
  assign draw      = wr_acc && (cmd_addr == A_DRAW);
  assign push      = draw && (shadow.width != 16'd0) && (shadow.height != 16'd0);
  assign re_valid  = (level != '0);
  assign pop       = re_valid && re_ready;

  // Shadow registers. Register writes are registered, so a write in the cycle
  // before DRAW is already in the shadow when DRAW snapshots it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow         <= '0;
      shadow.scale_x <= 16'd1;
      shadow.scale_y <= 16'd1;
      shadow.ct_type <= CT_DEFAULT;
    end else if (wr_acc) begin
      case (cmd_addr)
        A_START: begin
          shadow.start_x <= cmd_data[15:0];
          shadow.start_y <= cmd_data[31:16];
        end
        A_SIZE: begin
          shadow.width  <= cmd_data[15:0];
          shadow.height <= cmd_data[31:16];
        end
        A_SCALE: begin
          shadow.scale_x <= fix_scale(cmd_data[15:0]);
          shadow.scale_y <= fix_scale(cmd_data[31:16]);
        end
        A_CFG: begin
          shadow.mirror_x <= cmd_data[0];
          shadow.mirror_y <= cmd_data[1];
          shadow.use_ct   <= cmd_data[2];
          shadow.ct_type  <= fix_ct(cmd_data[2], cmd_data[7:3]);
          shadow.ct_base  <= cmd_data[31:16];
        end
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while level counts them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVLW'(1);
        2'b01:   level <= level - LVLW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (draw && !push && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  assign head        = mem[rd_ptr];
  assign re_start_x  = head.start_x;
  assign re_start_y  = head.start_y;
  assign re_width    = head.width;
  assign re_height   = head.height;
  assign re_scale_x  = head.scale_x;
  assign re_scale_y  = head.scale_y;
  assign re_mirror_x = head.mirror_x;
  assign re_mirror_y = head.mirror_y;
  assign re_use_ct   = head.use_ct;
  assign re_ct_type  = head.ct_type;
  assign re_ct_base  = head.ct_base;

  assign fifo_level = level;
  assign busy       = (level != '0) || !pipe_idle;

endmodule

// File: tb/tb_gpu_command_queue.sv
module tb_gpu_command_queue;

  localparam int DEPTH = 4;
  localparam int LVLW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_addr = '0;
  logic [31:0]     cmd_data = '0;
  logic            re_valid;
  logic            re_ready = 1'b0;
  logic [15:0]     re_start_x, re_start_y, re_width, re_height, re_scale_x, re_scale_y;
  logic            re_mirror_x, re_mirror_y, re_use_ct;
  logic [4:0]      re_ct_type;
  logic [15:0]     re_ct_base;
  logic            pipe_idle = 1'b1;
  logic            busy;
  logic [LVLW-1:0] fifo_level;
  logic [7:0]      drop_count;

  gpu_command_queue #(.DEPTH(DEPTH), .LVLW(LVLW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .re_valid(re_valid), .re_ready(re_ready),
    .re_start_x(re_start_x), .re_start_y(re_start_y),
    .re_width(re_width), .re_height(re_height),
    .re_scale_x(re_scale_x), .re_scale_y(re_scale_y),
    .re_mirror_x(re_mirror_x), .re_mirror_y(re_mirror_y),
    .re_use_ct(re_use_ct), .re_ct_type(re_ct_type), .re_ct_base(re_ct_base),
    .pipe_idle(pipe_idle), .busy(busy), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w0, w1, w2, w3;
    logic        drop;
    logic [15:0] sx, sy, wd, ht, scx, scy;
    logic        mx, my, uct;
    logic [4:0]  ct;
    logic [15:0] base;
  } vec_t;

  vec_t vecs[12];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_drop = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, input logic drop,
                              input logic [15:0] sx, sy, wd, ht, scx, scy,
                              input logic mx, my, uct, input logic [4:0] ct,
                              input logic [15:0] base);
    vec_t v;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3; v.drop = drop;
    v.sx = sx; v.sy = sy; v.wd = wd; v.ht = ht; v.scx = scx; v.scy = scy;
    v.mx = mx; v.my = my; v.uct = uct; v.ct = ct; v.base = base;
    return v;
  endfunction

  function automatic logic [127:0] job_of(input vec_t v);
    return {8'h0, v.sx, v.sy, v.wd, v.ht, v.scx, v.scy, v.mx, v.my, v.uct, v.ct, v.base};
  endfunction

  function automatic logic [127:0] act_job();
    return {8'h0, re_start_x, re_start_y, re_width, re_height, re_scale_x, re_scale_y,
            re_mirror_x, re_mirror_y, re_use_ct, re_ct_type, re_ct_base};
  endfunction

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    int waited;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    waited = 0;
    while (!cmd_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL write_timeout: addr %0d never accepted", a);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    re_ready = 1'b1;
    @(posedge clk);
    #1;
    re_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] seen[5];
    int got;

    //            w0            w1            w2            w3          drop sx       sy       wd       ht       scx      scy      mx my uct ct     base
    vecs[0]  = mk(32'h0002_0001, 32'h0003_0004, 32'h0001_0001, 32'h0000_0000, 0, 16'h0001, 16'h0002, 16'h0004, 16'h0003, 16'h0001, 16'h0001, 0, 0, 0, 5'd16, 16'h0000);
    vecs[1]  = mk(32'h1111_2222, 32'h0010_0020, 32'h0000_0000, 32'h0000_001C, 0, 16'h2222, 16'h1111, 16'h0020, 16'h0010, 16'h0001, 16'h0001, 0, 0, 1, 5'd16, 16'h0000);
    vecs[2]  = mk(32'h0000_0005, 32'h0001_0001, 32'h0000_FFFE, 32'hABCD_0047, 0, 16'h0005, 16'h0000, 16'h0001, 16'h0001, 16'hFFFE, 16'h0001, 1, 1, 1, 5'd8,  16'hABCD);
    vecs[3]  = mk(32'h0000_0006, 32'h0001_0001, 32'hFFFE_0000, 32'h1234_0020, 0, 16'h0006, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'hFFFE, 0, 0, 0, 5'd16, 16'h1234);
    vecs[4]  = mk(32'h0000_0007, 32'h0002_0002, 32'h8000_7FFF, 32'h0000_000C, 0, 16'h0007, 16'h0000, 16'h0002, 16'h0002, 16'h7FFF, 16'h8000, 0, 0, 1, 5'd1,  16'h0000);
    vecs[5]  = mk(32'h0000_0008, 32'h0002_0002, 32'h0003_0003, 32'h0000_0014, 0, 16'h0008, 16'h0000, 16'h0002, 16'h0002, 16'h0003, 16'h0003, 0, 0, 1, 5'd2,  16'h0000);
    vecs[6]  = mk(32'h0000_0009, 32'hFFFF_FFFF, 32'h0001_0001, 32'h5555_0084, 0, 16'h0009, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 1, 5'd16, 16'h5555);
    vecs[7]  = mk(32'h0000_000A, 32'h0001_0001, 32'h0001_0001, 32'h0000_0026, 0, 16'h000A, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 0, 1, 1, 5'd4,  16'h0000);
    vecs[8]  = mk(32'h0000_000B, 32'h0005_0000, 32'h0001_0001, 32'h0000_0000, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 5'd0,  16'h0000);
    vecs[9]  = mk(32'h0000_000C, 32'h0000_0007, 32'h0001_0001, 32'h0000_0000, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 5'd0,  16'h0000);
    vecs[10] = mk(32'h0000_000D, 32'h0001_0001, 32'h0001_0001, 32'h0000_0004, 0, 16'h000D, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 0, 0, 1, 5'd16, 16'h0000);
    vecs[11] = mk(32'h0000_000E, 32'h0001_0001, 32'h0001_0001, 32'h0000_00FC, 0, 16'h000E, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 0, 0, 1, 5'd16, 16'h0000);

    // Reset state
    pipe_idle = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy_not_idle", busy, 1);
    pipe_idle = 1'b1;
    #1;
    check("rst_busy_idle", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_re_valid", re_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_count, 0);
    check("rst_cmd_ready_after", cmd_ready, 1);

    // Basic job, consumer ready: valid for exactly one cycle
    write_reg(3'd0, 32'h0002_0001);
    write_reg(3'd1, 32'h0003_0004);
    re_ready = 1'b1;
    write_reg(3'd4, 32'h0);
    check("basic_valid", re_valid, 1);
    check("basic_job", act_job(), {8'h0, 16'd1, 16'd2, 16'd4, 16'd3, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 5'd16, 16'd0});
    check("basic_busy", busy, 1);
    @(posedge clk);
    #1;
    re_ready = 1'b0;
    check("basic_one_cycle", re_valid, 0);

    // Fill to DEPTH with consumer stalled, then a fifth DRAW while draining
    for (int i = 0; i < DEPTH; i++) begin
      write_reg(3'd0, 32'h10 + i);
      write_reg(3'd4, 32'h0);
    end
    check("full_level", fifo_level, DEPTH);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_head", re_start_x, 16'h10);
    got = 0;
    fork
      begin
        write_reg(3'd0, 32'h14);
        write_reg(3'd4, 32'h0);
      end
      begin
        for (int c = 0; c < 100 && got < 5; c++) begin
          @(negedge clk);
          re_ready = 1'b1;
          if (re_valid) begin
            seen[got] = re_start_x;
            got++;
          end
        end
        @(posedge clk);
        #1;
        re_ready = 1'b0;
      end
    join
    check("drain_count", got, 5);
    for (int i = 0; i < 5; i++) check($sformatf("drain_order%0d", i), seen[i], 16'h10 + i);
    check("drain_empty", re_valid, 0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      write_reg(3'd0, vecs[i].w0);
      write_reg(3'd1, vecs[i].w1);
      write_reg(3'd2, vecs[i].w2);
      write_reg(3'd3, vecs[i].w3);
      write_reg(3'd4, 32'h0);
      if (vecs[i].drop) begin
        exp_drop++;
        check($sformatf("vec%0d_no_valid", i), re_valid, 0);
        check($sformatf("vec%0d_drop", i), drop_count, exp_drop);
      end else begin
        check($sformatf("vec%0d_valid", i), re_valid, 1);
        check($sformatf("vec%0d_job", i), act_job(), job_of(vecs[i]));
        pop_one();
        check($sformatf("vec%0d_popped", i), re_valid, 0);
      end
    end

    // Push and pop in the same cycle at level 2
    write_reg(3'd1, 32'h0001_0001);
    write_reg(3'd0, 32'hA1);
    write_reg(3'd4, 32'h0);
    write_reg(3'd0, 32'hA2);
    write_reg(3'd4, 32'h0);
    write_reg(3'd0, 32'hA3);
    check("pp_level_before", fifo_level, 2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 3'd4;
    re_ready  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    re_ready  = 1'b0;
    check("pp_level_after", fifo_level, 2);
    check("pp_head", re_start_x, 16'hA2);
    pop_one();
    check("pp_next", re_start_x, 16'hA3);
    check("pp_level_one", fifo_level, 1);
    pop_one();
    check("pp_empty", re_valid, 0);

    // Drop counter saturation
    write_reg(3'd1, 32'h0005_0000);
    for (int i = 0; i < 252; i++) write_reg(3'd4, 32'h0);
    check("drop_254", drop_count, 254);
    write_reg(3'd4, 32'h0);
    check("drop_255", drop_count, 255);
    for (int i = 0; i < 47; i++) write_reg(3'd4, 32'h0);
    check("drop_sat", drop_count, 255);
    check("drop_no_valid", re_valid, 0);

    // Reset mid-handshake
    write_reg(3'd1, 32'h0009_0009);
    write_reg(3'd2, 32'h0005_0005);
    write_reg(3'd3, 32'h7777_0047);
    write_reg(3'd0, 32'h0000_00B1);
    write_reg(3'd4, 32'h0);
    check("mid_valid", re_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", re_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    write_reg(3'd1, 32'h0001_0001);
    write_reg(3'd4, 32'h0);
    check("post_rst_valid", re_valid, 1);
    check("post_rst_shadows", act_job(), {8'h0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 5'd16, 16'd0});
    pop_one();
    check("post_rst_empty", re_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
